// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the execute-stage divider.
package cpu_defs;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } div_state_e;

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  // Extra top bit on trial keeps the sign exact for a WIDTH+1 bit shifted remainder.
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, divisor_i};
    if (!trial[WIDTH+1]) begin
      rem_o = WIDTH'(trial);
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient (LO) and remainder (HI),
// one shift-and-subtract step per clock, fixed latency of WIDTH+1 cycles.
module divider_seq
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = cpu_defs::WIDTH,
  parameter int unsigned CNT_W = cpu_defs::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             dvd_neg_c, dvs_neg_c;
  logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c;
  logic [WIDTH-1:0] step_rem_c, step_quo_c;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_c),
    .quo_o     (step_quo_c)
  );

  // Operand magnitudes; the most negative value maps onto itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    dvd_neg_c = is_signed & dividend[WIDTH-1];
    dvs_neg_c = is_signed & divisor[WIDTH-1];
    dvd_mag_c = dvd_neg_c ? -dividend : dividend;
    dvs_mag_c = dvs_neg_c ? -divisor : divisor;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dvd_raw_d     = dvd_raw_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dz_d          = dz_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          quo_d         = dvd_mag_c;
          rem_d         = '0;
          dvs_d         = dvs_mag_c;
          dvd_raw_d     = dividend;
          q_neg_d       = dvd_neg_c ^ dvs_neg_c;
          r_neg_d       = dvd_neg_c;
          dz_d          = (divisor == '0);
          cnt_d         = CNT_W'(WIDTH);
          busy_d        = 1'b1;
          div_by_zero_d = 1'b0;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = step_rem_c;
        quo_d = step_quo_c;
        cnt_d = cnt_q - CNT_W'(1);
        // Last step: results are registered here so they appear alongside done.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          if (dz_q) begin
            quotient_d    = DIV_ZERO_QUOT[WIDTH-1:0];
            remainder_d   = dvd_raw_q;
            div_by_zero_d = 1'b1;
          end else begin
            quotient_d    = q_neg_q ? -step_quo_c : step_quo_c;
            remainder_d   = r_neg_q ? -step_rem_c : step_rem_c;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dvd_raw_q     <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      dvd_raw_q     <= dvd_raw_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed corner cases plus random operands against a
// 64-bit arithmetic reference for DIV/DIVU.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int unsigned total = 0;
  int unsigned bad   = 0;

  divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic, C-style remainder sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint sa, sb;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Issue one divide at the current negedge and follow it to completion.
  // extra_at: cycle after accept at which a stray start is pulsed (0 = none).
  // poke_done: also pulse start during the done cycle (must be ignored).
  // rst_at: cycle after accept at which reset is asserted (0 = none).
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int extra_at, input logic poke_done,
                         input int rst_at);
    logic [31:0] eq, er;
    logic        edz;
    logic        busy_ok;
    logic        no_done;
    int          k;
    ref_div(a, b, s, eq, er, edz);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    busy_ok = 1'b1;
    k       = 1;
    while (k <= 40) begin
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, ".rst_busy"}, 32'(busy), 32'd0);
        chk({tag, ".rst_done"}, 32'(done), 32'd0);
        chk({tag, ".rst_quo"}, quotient, 32'd0);
        chk({tag, ".rst_rem"}, remainder, 32'd0);
        chk({tag, ".rst_dz"}, 32'(div_by_zero), 32'd0);
        no_done = 1'b1;
        repeat (40) begin
          @(negedge clk);
          if (done || busy) no_done = 1'b0;
        end
        chk({tag, ".rst_quiet"}, 32'(no_done), 32'd1);
        return;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) break;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom);
      start     = (k == extra_at);
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'd33);
    chk({tag, ".busy"}, 32'(busy_ok), 32'd1);
    chk({tag, ".quo"}, quotient, eq);
    chk({tag, ".rem"}, remainder, er);
    chk({tag, ".dz"}, 32'(div_by_zero), 32'(edz));
    if (poke_done) begin
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".hold_quo"}, quotient, eq);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int          sel;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.quo", quotient, 32'd0);
    chk("reset.rem", remainder, 32'd0);
    chk("reset.dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 0, 1'b0, 0);
    chk("udiv_100_7.const_q", quotient, 32'd14);
    chk("udiv_100_7.const_r", remainder, 32'd2);
    run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, 0);
    chk("sdiv_m7_2.const_r", remainder, 32'hFFFF_FFFF);
    run_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0, 0);
    chk("sdiv_7_m2.const_q", quotient, 32'hFFFF_FFFD);
    run_div("dz_s", 32'h1234_5678, 32'd0, 1'b1, 0, 1'b0, 0);
    run_div("dz_u", 32'h1234_5678, 32'd0, 1'b0, 0, 1'b0, 0);
    chk("dz_u.const_r", remainder, 32'h1234_5678);
    run_div("dz_neg", 32'h8765_4321, 32'd0, 1'b1, 0, 1'b0, 0);
    run_div("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 0);
    chk("sovf.const_q", quotient, 32'h8000_0000);
    run_div("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, 0);
    run_div("stray_start", 32'd50, 32'd5, 1'b0, 10, 1'b1, 0);
    chk("stray_start.const_q", quotient, 32'd10);
    run_div("back2back", 32'd1000, 32'd33, 1'b0, 0, 1'b0, 0);
    run_div("reset_mid", 32'd12345, 32'd67, 1'b0, 0, 1'b0, 15);
    run_div("after_rst", 32'hFFFF_FF00, 32'd16, 1'b1, 0, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      a   = $urandom;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (sel == 4) a = 32'($urandom_range(0, 20));
      run_div($sformatf("rnd%0d", i), a, b, 1'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0,
              1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Multi-cycle restoring integer divider for the pipelined CPU's EX stage, serving DIV/DIVU.
- Computes quotient (LO) and remainder (HI) by one shift-and-subtract step per clock.
- The pipeline issues a request with a start pulse, stalls while busy is high, and captures results on done.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  WIDTH  numerator, sampled at accept.
- divisor  input  WIDTH  denominator, sampled at accept.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; results are valid in this cycle.
- quotient  output  WIDTH  result quotient; held until the next accept.
- remainder  output  WIDTH  result remainder; held until the next accept.
- div_by_zero  output  1  high with done when divisor == 0; held with the results.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; counter = 0. Reset wins over every other event, including mid-operation. Any in-flight divide is discarded and no done is produced.
- States: IDLE, RUN, FINISH.
- IDLE, start = 1:
  - Latch operand magnitudes: abs(x) when is_signed, otherwise raw.
  - Latch q_neg = is_signed & (dividend[MSB] ^ divisor[MSB]) and r_neg = is_signed & dividend[MSB].
  - Latch dz = (divisor == 0).
  - Clear the partial remainder, set counter = WIDTH, go to RUN.
- RUN, each cycle:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - trial = rem_shifted - divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise keep rem and the quotient LSB = 0.
  - Decrement the counter. Move to FINISH after the step where the counter reaches 1.
- FINISH:
  - done = 1 for exactly this cycle.
  - quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem.
  - If dz: quotient = all ones, remainder = original dividend, div_by_zero = 1.
  - Next state is IDLE.
- Latency: start accepted at edge N gives busy = 1 for cycles N+1 .. N+WIDTH+1 and done = 1 in cycle N+WIDTH+1 (33 cycles for WIDTH = 32). Latency is fixed, including divide-by-zero.
- busy stays high during FINISH and falls in the cycle after done.
- start while busy is ignored, with no effect on state or results. start in the same cycle as done is ignored. A start in the following IDLE cycle is accepted.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, div_by_zero 0. This falls out of the magnitude arithmetic with no special case.
- Input changes after accept have no effect; operands are registered.
- div_by_zero clears on the next accept.

Decomposition:
- Shared package (cpu_defs): WIDTH constant, divider state encoding (IDLE/RUN/FINISH), DIV_ZERO_QUOT = all-ones constant.
- Sub-module div_step: combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Bench-tested standalone.
- Sign fix-up (abs/negate) stays inline.

Test Plan:
1. Unsigned 100 / 7, start at cycle 0: done in cycle 33; quotient = 14, remainder = 2, div_by_zero = 0; busy high cycles 1..33.
2. Signed -7 / 2 (0xFFFFFFF9 / 0x2): quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1). Signed 7 / -2: quotient = 0xFFFFFFFD, remainder = 1.
3. Divide by zero, 0x12345678 / 0, either mode: done in cycle 33; quotient = 0xFFFFFFFF, remainder = 0x12345678, div_by_zero = 1.
4. Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Unsigned 0xFFFFFFFF / 1: quotient = 0xFFFFFFFF, remainder = 0.
5. Start 50 / 5, then pulse start with 9 / 3 at cycle 10: second request ignored; done once, at cycle 33, with quotient = 10, remainder = 0. Back-to-back start at cycle 34 is accepted.
6. rst asserted at cycle 15 of a divide: next cycle busy = 0, done = 0, outputs = 0, state IDLE; no done pulse follows; a new start afterwards completes normally.
